// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, wait-counter width, lane count.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W      = 4;
  localparam int BYTE_LANES = 4;

endpackage

// File: rtl/dm_array.sv
// Word-organised data array: synchronous byte-masked write, combinational read, contents never reset.
module dm_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8 * BYTE_LANES
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dm_responder.sv
// Handshaked data-memory slave: ack WAIT_CYCLES cycles after the cycle following accept (one-cycle pulse).
// ready only in IDLE/RESP; requests seen while BUSY are dropped, RESP accepts back-to-back with no bubble.
module dm_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8 * BYTE_LANES,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W+1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  ready,
  output logic                  ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err
);

  localparam int BE_W = DATA_W / 8;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              err_q;

  logic              accept, enter_resp;
  logic              acc_we, acc_aligned;
  logic [ADDR_W+1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata, arr_rdata;
  logic [BE_W-1:0]   acc_be;

  assign ready  = (state == IDLE) || (state == RESP);
  assign accept = ready && req;
  assign ack    = (state == RESP);
  assign err    = ack && err_q;

  // With zero wait states the access happens on the accept edge itself, so use the live request.
  assign acc_we      = accept ? we    : we_q;
  assign acc_addr    = accept ? addr  : addr_q;
  assign acc_wdata   = accept ? wdata : wdata_q;
  assign acc_be      = accept ? be    : be_q;
  assign acc_aligned = (acc_addr[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt  = BUSY;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
        cnt     <= CNT_W'(WAIT_CYCLES);
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (enter_resp) begin
        if (!acc_aligned) begin
          err_q <= 1'b1;
          rdata <= '0;
        end else begin
          err_q <= 1'b0;
          if (!acc_we) rdata <= arr_rdata;
        end
      end
    end
  end

  dm_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (enter_resp && acc_we && acc_aligned),
    .waddr (acc_addr[ADDR_W+1:2]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .raddr (acc_addr[ADDR_W+1:2]),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench: dut2 (WAIT_CYCLES=2) and dut0 (WAIT_CYCLES=0) share one stimulus bus.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        ready2, ack2, err2;
  logic [31:0] rdata2;
  logic        ready0, ack0, err0;
  logic [31:0] rdata0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready2), .ack(ack2), .rdata(rdata2), .err(err2)
  );

  dm_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  // Presents one request, drops req after the accept edge, waits (bounded) for the chosen DUT's ack.
  // lat = number of post-edge samples from the accept edge up to and including the ack cycle; -1 on timeout.
  task automatic txn(input int sel, input logic w, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic e, output int lat);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0;
    lat = -1; rd = '0; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if ((sel == 0) ? ack0 : ack2) begin
        lat = k;
        rd  = (sel == 0) ? rdata0 : rdata2;
        e   = (sel == 0) ? err0 : err2;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b1; we = 1'b1; addr = 12'h010; wdata = 32'hBAD0BAD0; be = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ready2 !== 1'b1) begin n_fail++; $display("FAIL rst_ready2: got %b want 1", ready2); end
    n_cmp++; if (ack2 !== 1'b0) begin n_fail++; $display("FAIL rst_ack2: got %b want 0", ack2); end
    n_cmp++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL rst_err2: got %b want 0", err2); end
    n_cmp++; if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL rst_rdata2: got %h want 0", rdata2); end
    n_cmp++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL rst_ready0: got %b want 1", ready0); end
    n_cmp++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL rst_ack0: got %b want 0", ack0); end
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e; int lat;
    txn(2, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, e, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", e); end
    @(posedge clk); #1;
    n_cmp++; if (ack2 !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse: got %b want 0", ack2); end
    txn(2, 1'b0, 12'h010, 32'h0, 4'h0, rd, e, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", e); end
    @(posedge clk); #1;
    n_cmp++; if (rdata2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold: got %h want deadbeef", rdata2); end
    n_cmp++; if (ack2 !== 1'b0) begin n_fail++; $display("FAIL rd_ack_pulse: got %b want 0", ack2); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; logic e; int lat;
    txn(2, 1'b1, 12'h020, 32'h11223344, 4'hF, rd, e, lat);
    txn(2, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, rd, e, lat);
    txn(2, 1'b0, 12'h020, 32'h0, 4'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL mask_data: got %h want 11bb33dd", rd); end
    txn(2, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, rd, e, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL be0_latency: got %0d want 3", lat); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL be0_err: got %b want 0", e); end
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL wr_keeps_rdata: got %h want 11bb33dd", rd); end
    txn(2, 1'b0, 12'h020, 32'h0, 4'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be0_unchanged: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic e; int lat;
    txn(2, 1'b0, 12'h022, 32'h0, 4'h0, rd, e, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL mis_latency: got %0d want 3", lat); end
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b want 1", e); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h want 0", rd); end
    @(posedge clk); #1;
    n_cmp++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL mis_err_clears: got %b want 0", err2); end
    txn(2, 1'b1, 12'h021, 32'h00000000, 4'hF, rd, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL mis_wr_err: got %b want 1", e); end
    txn(2, 1'b0, 12'h020, 32'h0, 4'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL mis_no_access: got %h want 11bb33dd", rd); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL aligned_err: got %b want 0", e); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic e; int lat; int rises;
    txn(2, 1'b1, 12'h040, 32'hCAFEF00D, 4'hF, rd, e, lat);
    req = 1'b1; we = 1'b1; addr = 12'h040; wdata = 32'h0BADCAFE; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    n_cmp++; if (ready2 !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got ready %b want 0", ready2); end
    rst = 1'b0;
    #1;
    n_cmp++; if (ready2 !== 1'b1) begin n_fail++; $display("FAIL mid_async_ready: got %b want 1", ready2); end
    n_cmp++; if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL mid_rdata_clr: got %h want 0", rdata2); end
    @(posedge clk); #1;
    rst = 1'b1;
    rises = 0;
    for (int k = 0; k < 6; k++) begin
      if (ack2 === 1'b1) rises++;
      @(posedge clk); #1;
    end
    n_cmp++; if (rises !== 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d acks want 0", rises); end
    txn(2, 1'b0, 12'h040, 32'h0, 4'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mid_old_value: got %h want cafef00d", rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [11:0] a_t [4];
    logic        w_t [4];
    logic [31:0] d_t [4];
    logic [31:0] rd; logic e; int lat;
    a_t[0] = 12'h050; w_t[0] = 1'b1; d_t[0] = 32'h12345678;
    a_t[1] = 12'h050; w_t[1] = 1'b0; d_t[1] = 32'h12345678;
    a_t[2] = 12'h010; w_t[2] = 1'b0; d_t[2] = 32'hDEADBEEF;
    a_t[3] = 12'h020; w_t[3] = 1'b0; d_t[3] = 32'h11BB33DD;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_pre: got %b want 1", ready0); end
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; we = w_t[i]; addr = a_t[i]; wdata = d_t[i]; be = 4'hF;
      @(posedge clk); #1;
      n_cmp++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b want 1", i, ack0); end
      n_cmp++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ready0); end
      if (!w_t[i]) begin
        n_cmp++; if (rdata0 !== d_t[i]) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rdata0, d_t[i]); end
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_end: got %b want 0", ack0); end
    // dut2: a second request held during BUSY must not be taken
    repeat (5) @(posedge clk);
    #1;
    req = 1'b1; we = 1'b0; addr = 12'h010; wdata = 32'h0; be = 4'h0;
    @(posedge clk); #1;
    addr = 12'h020;
    lat = -1; rd = '0; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (ack2) begin
        lat = k; rd = rdata2; e = err2;
        break;
      end
      n_cmp++; if (ready2 !== 1'b0) begin n_fail++; $display("FAIL busy_ready[%0d]: got %b want 0", k, ready2); end
      @(posedge clk); #1;
    end
    req = 1'b0;
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL busy_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL busy_ignored: got %h want deadbeef", rd); end
    @(posedge clk); #1;
    n_cmp++; if (ack2 !== 1'b0) begin n_fail++; $display("FAIL busy_ack_end: got %b want 0", ack2); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_misaligned();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
